// File: rtl/mem_copy_engine_pkg.sv
// Shared constants, the address-width helper and the state encoding for the
// memory copy engine.
package mem_copy_engine_pkg;

  localparam int DEFAULT_WIDTH         = 256;
  localparam int DEFAULT_MAX_MEM_DEPTH = 320;

  // Smallest w with 2**w >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int DEFAULT_AW = clog2(DEFAULT_MAX_MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control handshake plus source-read / destination-write buses of the copy engine.
// The master side is the engine itself; the slave side is the host and memories.
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = DEFAULT_AW
);

  logic             i_start;
  logic [AW-1:0]    i_start_addr;
  logic [AW-1:0]    i_end_addr;
  logic [AW-1:0]    o_mem_in_addr;
  logic             o_mem_in_en;
  logic [WIDTH-1:0] i_mem_in;
  logic [AW-1:0]    o_mem_out_addr;
  logic             o_mem_out_en;
  logic [WIDTH-1:0] o_mem_out;
  logic             o_done;

  modport master (
    input  i_start, i_start_addr, i_end_addr, i_mem_in,
    output o_mem_in_addr, o_mem_in_en, o_mem_out_addr, o_mem_out_en, o_mem_out, o_done
  );

  modport slave (
    output i_start, i_start_addr, i_end_addr, i_mem_in,
    input  o_mem_in_addr, o_mem_in_en, o_mem_out_addr, o_mem_out_en, o_mem_out, o_done
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Copies an inclusive address range from a source SRAM to the same addresses in
// a destination SRAM at one word per cycle; the write path trails reads by one cycle.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int MAX_MEM_DEPTH = DEFAULT_MAX_MEM_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_copy_engine_if.master bus
);

  localparam int AW = clog2(MAX_MEM_DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] wr_addr_q;
  logic          wr_en_q;
  logic          rd_en;
  logic          done;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    rd_en   = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_start_addr <= bus.i_end_addr) begin
            ptr_d   = bus.i_start_addr;
            end_d   = bus.i_end_addr;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        // The end address is inclusive, so the pointer never has to wrap.
        if (ptr_q == end_q) begin
          state_d = ST_DRAIN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      end_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      wr_en_q   <= rd_en;
      wr_addr_q <= ptr_q;
    end
  end

  // Source data is already registered inside the SRAM, so it passes straight through.
  assign bus.o_mem_in_addr  = ptr_q;
  assign bus.o_mem_in_en    = rd_en;
  assign bus.o_mem_out_addr = wr_addr_q;
  assign bus.o_mem_out_en   = wr_en_q;
  assign bus.o_mem_out      = WIDTH'(bus.i_mem_in);
  assign bus.o_done         = done;

endmodule

// File: tb/sram.sv
// Behavioural single-port SRAM: synchronous write, registered read, active-low
// chip enable, i_rdWr_N=1 reads and 0 writes.
module sram #(
  parameter int    WIDTH      = 256,
  parameter int    ADDR_WIDTH = 9,
  parameter string FILE       = ""
) (
  input  logic                  i_clk,
  input  logic                  i_ce_N,
  input  logic                  i_rdWr_N,
  input  logic [ADDR_WIDTH-1:0] i_ramAddr,
  input  logic [WIDTH-1:0]      i_ramData,
  output logic [WIDTH-1:0]      o_ramData
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  initial begin
    for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
  end

  // NOTE: the array has no reset; contents survive i_rst like a real macro.
  always @(posedge i_clk) begin
    if (!i_ce_N) begin
      if (!i_rdWr_N) mem[i_ramAddr] <= i_ramData;
      else           o_ramData      <= mem[i_ramAddr];
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: stimulus queues the expected writes and
// done pulse, a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_copy_engine;

  localparam int W     = 256;
  localparam int AW    = 9;
  localparam int DEPTH = 320;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   wr_count = 0;
  int   rd_count = 0;

  wr_t          wr_q[$];
  int           done_q[$];
  logic [W-1:0] exp_dst [2**AW];
  logic [W-1:0] dst_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_copy_engine_if #(.WIDTH(W), .AW(AW)) bus ();

  mem_copy_engine #(.WIDTH(W), .MAX_MEM_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  sram #(.WIDTH(W), .ADDR_WIDTH(AW)) src (
    .i_clk     (clk),
    .i_ce_N    (~bus.o_mem_in_en),
    .i_rdWr_N  (1'b1),
    .i_ramAddr (bus.o_mem_in_addr),
    .i_ramData ('0),
    .o_ramData (bus.i_mem_in)
  );

  sram #(.WIDTH(W), .ADDR_WIDTH(AW)) dst (
    .i_clk     (clk),
    .i_ce_N    (~bus.o_mem_out_en),
    .i_rdWr_N  (1'b0),
    .i_ramAddr (bus.o_mem_out_addr),
    .i_ramData (bus.o_mem_out),
    .o_ramData (dst_rdata)
  );

  function automatic logic [W-1:0] pattern(input int k);
    return {16{k[15:0]}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (bus.o_mem_in_en === 1'b1) rd_count++;
    if (bus.o_mem_out_en === 1'b1) begin
      wr_count++;
      if (wr_q.size() == 0) begin
        check("unexpected_write", W'(bus.o_mem_out_en), '0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_cycle", W'(cyc), W'(e.cyc));
        check("wr_addr", W'(bus.o_mem_out_addr), W'(e.addr));
        check("wr_data", bus.o_mem_out, e.data);
      end
    end
    if (bus.o_done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", W'(bus.o_done), '0);
      end else begin
        int d;
        d = done_q.pop_front();
        check("done_cycle", W'(cyc), W'(d));
      end
    end
  end

  // Issues a start; expected writes land on spec cycles 2..N+1, i.e. cyc s+1..s+N,
  // and done on spec cycle N+2 (cyc s+N+1). max_wr truncates for the abort case.
  task automatic start_copy(input int sa, input int ea, input int max_wr,
                            input bit want_done, output int s);
    int n;
    @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_start_addr = AW'(sa);
    bus.i_end_addr   = AW'(ea);
    s = cyc + 1;
    if (sa <= ea) begin
      n = ea - sa + 1;
      for (int k = 0; k < n; k++) begin
        if (max_wr < 0 || k < max_wr) begin
          wr_q.push_back('{cyc: s + 1 + k, addr: AW'(sa + k), data: pattern(sa + k)});
          exp_dst[sa + k] = pattern(sa + k);
        end
      end
      if (want_done) done_q.push_back(s + n + 1);
    end else if (want_done) begin
      done_q.push_back(s);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (wr_q.size() != 0 || done_q.size() != 0) begin
      check("timeout_pending", W'(wr_q.size() + done_q.size()), '0);
      wr_q.delete();
      done_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_dst();
    for (int i = 0; i < 2**AW; i++) begin
      dst.mem[i] = '0;
      exp_dst[i] = '0;
    end
    wr_count = 0;
    rd_count = 0;
  endtask

  task automatic check_dst(input string name);
    for (int i = 0; i < 2**AW; i++) begin
      if (dst.mem[i] !== exp_dst[i]) check(name, dst.mem[i], exp_dst[i]);
      else n_cmp++;
    end
  endtask

  initial begin
    int s;
    rst              = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_start_addr = '0;
    bus.i_end_addr   = '0;
    for (int k = 0; k < 2**AW; k++) src.mem[k] = pattern(k);
    clear_dst();
    repeat (3) @(negedge clk);

    check("rst_in_en",    W'(bus.o_mem_in_en),    '0);
    check("rst_out_en",   W'(bus.o_mem_out_en),   '0);
    check("rst_done",     W'(bus.o_done),         '0);
    check("rst_in_addr",  W'(bus.o_mem_in_addr),  '0);
    check("rst_out_addr", W'(bus.o_mem_out_addr), '0);
    rst = 1'b0;
    @(negedge clk);

    // Full 0..319 copy: done on spec cycle 322.
    clear_dst();
    start_copy(0, 319, -1, 1'b1, s);
    wait_drain(500);
    check("full_wr_count", W'(wr_count), W'(320));
    check("full_rd_count", W'(rd_count), W'(320));
    check_dst("full_dst");

    // Sub-range 10..20: done on spec cycle 13, other addresses stay 0.
    clear_dst();
    start_copy(10, 20, -1, 1'b1, s);
    wait_drain(100);
    check("sub_wr_count", W'(wr_count), W'(11));
    check_dst("sub_dst");

    // Single word at 5: write on spec cycle 2, done on 3.
    clear_dst();
    start_copy(5, 5, -1, 1'b1, s);
    wait_drain(50);
    check("single_wr_count", W'(wr_count), W'(1));
    check("single_rd_count", W'(rd_count), W'(1));
    check_dst("single_dst");

    // Inverted range 8..3: no enables, done on spec cycle 1.
    clear_dst();
    start_copy(8, 3, -1, 1'b1, s);
    wait_drain(50);
    check("inv_wr_count", W'(wr_count), '0);
    check("inv_rd_count", W'(rd_count), '0);
    check_dst("inv_dst");

    // Busy restart with a new end address mid-copy must be ignored.
    clear_dst();
    start_copy(0, 99, -1, 1'b1, s);
    while (cyc < s + 20) @(negedge clk);
    bus.i_start      = 1'b1;
    bus.i_start_addr = AW'(0);
    bus.i_end_addr   = AW'(50);
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_drain(200);
    check("busy_wr_count", W'(wr_count), W'(100));
    check_dst("busy_dst");

    // Reset sampled at the edge closing spec cycle 30: 29 writes, no done.
    clear_dst();
    start_copy(0, 319, 29, 1'b0, s);
    while (cyc < s + 29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_en",  W'(bus.o_mem_in_en),  '0);
    check("abort_out_en", W'(bus.o_mem_out_en), '0);
    check("abort_done",   W'(bus.o_done),       '0);
    rst = 1'b0;
    wait_drain(50);
    repeat (20) @(negedge clk);
    check("abort_wr_count", W'(wr_count), W'(29));
    check("abort_rd_count", W'(rd_count), W'(30));
    check_dst("abort_dst");

    // Recovery copy 0..3 after the abort.
    wr_count = 0;
    start_copy(0, 3, -1, 1'b1, s);
    wait_drain(50);
    check("recover_wr_count", W'(wr_count), W'(4));
    check_dst("recover_dst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
